// File: rtl/ref_sched.sv
// Refresh scheduler: interval timer plus a credit counter of outstanding
// AUTO REFRESH commands, handed to the command arbiter via ref_req/ref_ack.
module ref_sched #(
  parameter int TREFI_CYC = 780,
  parameter int CNT_W     = 10,
  parameter int MAX_PEND  = 8,
  parameter int PEND_W    = 4,
  parameter int URGENT_TH = 6,
  parameter int LAZY_TH   = 1
) (
  input  logic              clk,
  input  logic              soft_rst,
  input  logic              rt_en,
  input  logic              ctrl_idle,
  input  logic              ref_ack,
  input  logic              ovf_clr,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ref_ovf
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TREFI_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] LAZY_LVL = PEND_W'(LAZY_TH);
  localparam logic [PEND_W-1:0] URG_LVL  = PEND_W'(URGENT_TH);

  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pend_next;
  logic              tick;
  logic              acc;
  logic              lost;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    lost      = 1'b0;
    pend_next = pend_cnt;
    tick      = rt_en && (cnt == CNT_LAST);
    // Only an ack against a request we are actually showing earns a credit back.
    acc       = rt_en && ref_ack && ref_req;
    if (tick && !acc) begin
      if (pend_cnt == PEND_MAX) lost = 1'b1;
      else                      pend_next = pend_cnt + 1'b1;
    end else if (acc && !tick) begin
      pend_next = pend_cnt - 1'b1;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      cnt        <= '0;
      pend_cnt   <= '0;
      ref_req    <= 1'b0;
      ref_urgent <= 1'b0;
      ref_ovf    <= 1'b0;
    end else begin
      if (!rt_en) begin
        cnt        <= '0;
        pend_cnt   <= '0;
        ref_req    <= 1'b0;
        ref_urgent <= 1'b0;
      end else begin
        cnt        <= tick ? '0 : cnt + 1'b1;
        pend_cnt   <= pend_next;
        ref_req    <= (pend_next >= LAZY_LVL) || (ctrl_idle && (pend_next != '0));
        ref_urgent <= (pend_next >= URG_LVL);
      end
      // A lost tick in the same cycle beats the clear request.
      if (lost)         ref_ovf <= 1'b1;
      else if (ovf_clr) ref_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ref_sched.sv
// Directed bench for ref_sched: eager instance (LAZY_TH=1) and lazy instance
// (LAZY_TH=3), both with TREFI_CYC=10, MAX_PEND=4, URGENT_TH=3.
module tb_ref_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Eager instance signals
  logic       rst_a = 1'b1, en_a = 1'b0, idle_a = 1'b0, ack_a = 1'b0, clr_a = 1'b0;
  logic       req_a, urg_a, ovf_a;
  logic [2:0] pend_a;
  // Lazy instance signals
  logic       rst_b = 1'b1, en_b = 1'b0, idle_b = 1'b0, ack_b = 1'b0, clr_b = 1'b0;
  logic       req_b, urg_b, ovf_b;
  logic [2:0] pend_b;

  int vectors = 0;
  int miscompares = 0;

  ref_sched #(.TREFI_CYC(10), .CNT_W(4), .MAX_PEND(4), .PEND_W(3),
              .URGENT_TH(3), .LAZY_TH(1)) dut_a (
    .clk(clk), .soft_rst(rst_a), .rt_en(en_a), .ctrl_idle(idle_a),
    .ref_ack(ack_a), .ovf_clr(clr_a), .ref_req(req_a), .ref_urgent(urg_a),
    .pend_cnt(pend_a), .ref_ovf(ovf_a));

  ref_sched #(.TREFI_CYC(10), .CNT_W(4), .MAX_PEND(4), .PEND_W(3),
              .URGENT_TH(3), .LAZY_TH(3)) dut_b (
    .clk(clk), .soft_rst(rst_b), .rt_en(en_b), .ctrl_idle(idle_b),
    .ref_ack(ack_b), .ovf_clr(clr_b), .ref_req(req_b), .ref_urgent(urg_b),
    .pend_cnt(pend_b), .ref_ovf(ovf_b));

  // Advance n edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_pend", 32'(pend_a), 0);
    check("rst_req",  32'(req_a),  0);
    check("rst_urg",  32'(urg_a),  0);
    check("rst_ovf",  32'(ovf_a),  0);

    // Eager basic: cycle 0 starts here
    rst_a = 1'b0; en_a = 1'b1;
    step(9);
    check("c9_pend", 32'(pend_a), 0);
    check("c9_req",  32'(req_a),  0);
    step(1);
    check("c10_pend", 32'(pend_a), 1);
    check("c10_req",  32'(req_a),  1);
    check("c10_urg",  32'(urg_a),  0);
    step(10);
    check("c20_pend", 32'(pend_a), 2);
    check("c20_urg",  32'(urg_a),  0);
    step(10);
    check("c30_pend", 32'(pend_a), 3);
    check("c30_urg",  32'(urg_a),  1);
    step(10);
    check("c40_pend", 32'(pend_a), 4);
    check("c40_ovf",  32'(ovf_a),  0);

    // Overflow and clear
    step(10);
    check("c50_pend", 32'(pend_a), 4);
    check("c50_ovf",  32'(ovf_a),  1);
    step(5);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    check("c56_ovf", 32'(ovf_a), 0);

    // Simultaneous tick and ack at MAX_PEND (tick cycle 59)
    step(3);
    ack_a = 1'b1;
    step(1);
    check("c60_pend", 32'(pend_a), 4);
    check("c60_ovf",  32'(ovf_a),  0);

    // Ack handshake: drain 4 -> 0, then one ignored ack
    step(1);
    check("c61_pend", 32'(pend_a), 3);
    step(1);
    check("c62_pend", 32'(pend_a), 2);
    check("c62_req",  32'(req_a),  1);
    step(1);
    check("c63_pend", 32'(pend_a), 1);
    check("c63_urg",  32'(urg_a),  0);
    step(1);
    check("c64_pend", 32'(pend_a), 0);
    check("c64_req",  32'(req_a),  0);
    step(1);
    ack_a = 1'b0;
    check("c65_pend", 32'(pend_a), 0);
    check("c65_req",  32'(req_a),  0);

    // Refill to overflow (ticks at 69..109), then one ack -> pend 3
    step(45);
    check("c110_pend", 32'(pend_a), 4);
    check("c110_ovf",  32'(ovf_a),  1);
    ack_a = 1'b1;
    step(1);
    ack_a = 1'b0;
    check("c111_pend", 32'(pend_a), 3);
    check("c111_urg",  32'(urg_a),  1);

    // Disable keeps ovf, reset clears it, re-enable restarts the interval
    en_a = 1'b0;
    step(1);
    check("dis_pend", 32'(pend_a), 0);
    check("dis_req",  32'(req_a),  0);
    check("dis_urg",  32'(urg_a),  0);
    check("dis_ovf",  32'(ovf_a),  1);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    check("rst2_ovf", 32'(ovf_a), 0);
    en_a = 1'b1;
    step(9);
    check("re9_pend", 32'(pend_a), 0);
    step(1);
    check("re10_pend", 32'(pend_a), 1);
    check("re10_req",  32'(req_a),  1);

    // Lazy mode, LAZY_TH=3
    rst_b = 1'b0; en_b = 1'b1; idle_b = 1'b0;
    step(20);
    check("lz20_pend", 32'(pend_b), 2);
    check("lz20_req",  32'(req_b),  0);
    idle_b = 1'b1;
    step(1);
    check("lz21_req", 32'(req_b), 1);
    idle_b = 1'b0;
    step(1);
    check("lz22_req", 32'(req_b), 0);
    step(7);
    check("lz29_req", 32'(req_b), 0);
    step(1);
    check("lz30_pend", 32'(pend_b), 3);
    check("lz30_req",  32'(req_b),  1);
    check("lz30_urg",  32'(urg_b),  1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ref_sched.md
Name: ref_sched

Overview:
Parametrised refresh scheduler for the SDRAM controller. It replaces the single-flag refresh timer with an interval counter and a pending-refresh credit counter. A req/ack handshake connects it to the command arbiter. The block supports postponed refresh (lazy threshold or idle pull), an urgent escalation flag, and a sticky overflow error.

Parameters:
TREFI_CYC, 780, refresh interval in clk cycles (7.8 us at 100 MHz); legal range 2..2^CNT_W.
CNT_W, 10, interval counter width.
MAX_PEND, 8, maximum outstanding refreshes (JEDEC postpone limit); legal range 1..15.
PEND_W, 4, pending counter width; must satisfy 2^PEND_W > MAX_PEND.
URGENT_TH, 6, pending count at which ref_urgent asserts; legal range 1..MAX_PEND.
LAZY_TH, 1, pending count at which ref_req asserts regardless of idle; 1 = eager; legal range 1..MAX_PEND.

Ports:
clk  in  1  system clock, 100 MHz
soft_rst  in  1  synchronous reset, active-high
rt_en  in  1  scheduler enable (SDRAM init complete)
ctrl_idle  in  1  arbiter has no pending read/write; allows early refresh
ref_ack  in  1  one-cycle pulse: arbiter issued one AUTO REFRESH
ovf_clr  in  1  clears ref_ovf
ref_req  out  1  refresh requested
ref_urgent  out  1  pending count >= URGENT_TH; arbiter must refresh before new traffic
pend_cnt  out  PEND_W  outstanding refresh count
ref_ovf  out  1  sticky: a tick was lost at MAX_PEND

Behaviour:
- All state is updated on posedge clk. soft_rst=1 has priority over everything: cnt=0, pend_cnt=0, ref_req=0, ref_urgent=0, ref_ovf=0.
- Interval counter, rt_en=1:
  - cnt increments each cycle.
  - When cnt==TREFI_CYC-1, tick=1 (internal, combinational) and cnt wraps to 0 at the next edge.
  - The first tick therefore occurs TREFI_CYC cycles after rt_en rises.
- rt_en=0: cnt forced to 0, pend_cnt forced to 0, ref_req and ref_urgent forced to 0. ref_ovf keeps its value. ref_ack is ignored.
- Ack validity: acc = ref_ack && ref_req, using the registered ref_req. An ack while ref_req=0 is ignored and does not change pend_cnt.
- pend_next rules:
  - tick and not acc: pend+1. At MAX_PEND, pend stays at MAX_PEND and ref_ovf is set.
  - acc and not tick: pend-1.
  - tick and acc together: pend unchanged, no overflow, even at MAX_PEND.
  - otherwise: pend unchanged.
- pend_cnt never underflows; it only decrements on acc, and acc requires pend>0.
- Outputs are registered from pend_next at the same edge:
  - ref_req = (pend_next >= LAZY_TH) or (ctrl_idle and pend_next > 0), where ctrl_idle is the value sampled at that edge.
  - ref_urgent = pend_next >= URGENT_TH.
- Latency: tick cycle to ref_req high is 1 cycle. An acc that brings pend to 0, or below LAZY_TH while ctrl_idle=0, drops ref_req at that same edge, so the arbiter sees no stale request.
- ref_ovf: set on a lost tick; cleared by ovf_clr only when no lost tick occurs in that cycle (set wins).
- Reset mid-operation is allowed at any cycle; the next tick again occurs TREFI_CYC cycles after reset release with rt_en=1.

Test Plan:
Use TREFI_CYC=10, MAX_PEND=4, URGENT_TH=3, LAZY_TH=1 unless stated.

1. Eager basic: reset, then rt_en=1 from cycle 0, no ack → ref_req rises at the edge after cycle 9. pend_cnt=1 at cycle 10, 2 at cycle 20, 3 at cycle 30; ref_urgent=1 from cycle 30.
2. Overflow: continue scenario 1 with no ack → pend_cnt=4 at cycle 40. At cycle 50, pend_cnt stays 4 and ref_ovf=1. Pulse ovf_clr at cycle 55 → ref_ovf=0 at cycle 56.
3. Ack handshake with pend_cnt=2, ref_req=1: ack at cycle k → pend_cnt=1 at k+1. Ack at k+1 → pend_cnt=0 and ref_req=0 at k+2. Ack at k+2 is ignored; pend_cnt stays 0.
4. Simultaneous: pend_cnt=4 and ack asserted on the tick cycle → pend_cnt stays 4, ref_ovf stays 0.
5. Lazy mode, LAZY_TH=3, ctrl_idle=0:
   - After 2 ticks, pend_cnt=2 with ref_req=0.
   - Raise ctrl_idle → ref_req=1 next edge.
   - Drop ctrl_idle → ref_req=0 next edge.
   - Third tick → ref_req=1 regardless of ctrl_idle.
6. Disable/reset: with pend_cnt=3 and ref_ovf=1, drop rt_en → pend_cnt=0, ref_req=0, ref_urgent=0, ref_ovf still 1. Assert soft_rst → ref_ovf=0. Re-enable → first tick 10 cycles later.
